// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups.
// Each stage resolves STAGE_GROUPS groups and forwards its ripple carry to the next stage.
module cla_adder_pipe #(
  parameter int WIDTH        = 16,
  parameter int STAGE_GROUPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int GW     = 4 * STAGE_GROUPS;
  localparam int STAGES = (GW > 0) ? (WIDTH / GW) : 1;

  generate
    if (STAGE_GROUPS < 1 || WIDTH < GW || (WIDTH % GW) != 0) begin : g_param_check
      $error("cla_adder_pipe: WIDTH must be a positive multiple of 4*STAGE_GROUPS");
    end
  endgenerate

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cm;
  } stg_t;

  // Returns {carry out of bit 3, carry into bit 3, sum[3:0]}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

  // Resolves the groups owned by stage k; lower sum bits pass through untouched.
  function automatic stg_t stage_calc(input int k, input logic [WIDTH-1:0] ai,
                                      input logic [WIDTH-1:0] bi,
                                      input logic [WIDTH-1:0] si, input logic ci);
    stg_t       o;
    logic [5:0] r;
    logic       cy;
    o.s  = si;
    o.cm = 1'b0;
    cy   = ci;
    for (int g = 0; g < STAGE_GROUPS; g++) begin
      r = cla4(ai[k*GW + 4*g +: 4], bi[k*GW + 4*g +: 4], cy);
      o.s[k*GW + 4*g +: 4] = r[3:0];
      o.cm = r[4];
      cy   = r[5];
    end
    o.c = cy;
    return o;
  endfunction

  logic             adv, accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  logic [WIDTH-1:0] a_p [STAGES];
  logic [WIDTH-1:0] b_p [STAGES];
  logic [WIDTH-1:0] s_p [STAGES];
  logic [STAGES-1:0] c_p, cm_p, vld_p;
  stg_t             nx  [STAGES];
  logic             unused_bits;

  assign adv      = !out_valid || out_ready;
  assign in_ready = reset && adv;
  assign accept   = in_valid && in_ready;
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub | cin;

  always_comb begin
    nx[0] = stage_calc(0, a, b_eff, '0, c_eff);
    for (int k = 1; k < STAGES; k++) begin
      nx[k] = stage_calc(k, a_p[k-1], b_p[k-1], s_p[k-1], c_p[k-1]);
    end
  end

  // ---- stage registers: control ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p[0] <= accept;
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // ---- stage registers: datapath ----
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p[0] <= a;
      b_p[0] <= b_eff;
      for (int k = 1; k < STAGES; k++) begin
        a_p[k] <= a_p[k-1];
        b_p[k] <= b_p[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        s_p[k]  <= nx[k].s;
        c_p[k]  <= nx[k].c;
        cm_p[k] <= nx[k].cm;
      end
    end
    // Only the output stage is cleared, so the visible result reads zero after reset.
    if (!reset) begin
      s_p[STAGES-1]  <= '0;
      c_p[STAGES-1]  <= 1'b0;
      cm_p[STAGES-1] <= 1'b0;
    end
  end

  // Low operand bits of each stage and the final operand copies are never consumed.
  always_comb begin
    unused_bits = ^cm_p;
    for (int k = 0; k < STAGES; k++) unused_bits = unused_bits ^ (^a_p[k]) ^ (^b_p[k]);
  end

  assign out_valid = vld_p[STAGES-1];
  assign sum       = s_p[STAGES-1];
  assign cout      = c_p[STAGES-1];
  assign ovf       = c_p[STAGES-1] ^ cm_p[STAGES-1];

endmodule
